pwm_stereo_modulator: RTL
=========================

PWM_STEREO_MODULATOR -- requirements
Module: pwm_stereo_modulator

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 16, width of signed PCM input samples.
REQ-002 SHALL have parameter PWM_W, default 8, PWM resolution in bits (period = 2^PWM_W cycles); PWM_W <= SAMPLE_W.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port sample_valid  input  1  stereo sample pair offered by upstream I2S deserializer.
REQ-006 SHALL have port sample_left  input  SAMPLE_W  two's-complement left sample.
REQ-007 SHALL have port sample_right  input  SAMPLE_W  two's-complement right sample.
REQ-008 SHALL have port sample_ready  output  1  block can accept a pair this cycle.
REQ-009 SHALL have port left_channel  output  1  registered left PWM output.
REQ-010 SHALL have port right_channel  output  1  registered right PWM output.
REQ-011 SHALL have port underrun_cnt  output  8  saturating count of periods started with no new sample.

Function
REQ-012 SHALL run a free PWM counter 0..2^PWM_W-1, incrementing every cycle, wrapping to 0; "wrap cycle" = counter at 2^PWM_W-1.
REQ-013 SHALL convert each sample to duty = top PWM_W bits of the sample with MSB inverted (offset binary); 0x8000 -> 0, 0x0000 -> 2^(PWM_W-1), 0x7FFF -> 2^PWM_W-1 (for 16/8).
REQ-014 SHALL hold one shadow pair (both duties) plus a shadow_full flag.
REQ-015 SHALL drive sample_ready = !shadow_full combinationally; accept on sample_valid && sample_ready, writing shadow and setting shadow_full next edge.
REQ-016 SHALL, on wrap cycle with shadow_full=1, copy shadow to active duties and clear shadow_full at the same edge.
REQ-017 SHALL, on wrap cycle with shadow_full=0, keep previous active duties and flag an underrun.
REQ-018 SHALL, if accept and wrap coincide with shadow empty, store the new pair in shadow only; it becomes active at the following wrap; this counts as underrun.
REQ-019 SHALL register left_channel = (counter < active_left), right_channel likewise; output lags counter by 1 cycle.
REQ-020 SHALL give duty 0 -> output constantly low, duty 2^PWM_W-1 -> high 2^PWM_W-1 of 2^PWM_W cycles (never 100%).
REQ-021 SHALL change active duties only at wrap, so no period contains a glitch or mixed duty.
REQ-022 SHALL ignore sample_left/right when sample_valid=0 or sample_ready=0; upstream holds data while stalled.

Reset
REQ-023 SHALL, while rst=1, asynchronously force counter=0, shadow_full=0, active duties=2^(PWM_W-1) (midscale silence), left_channel=0, right_channel=0, underrun_cnt=0.
REQ-024 SHALL, on rst mid-period, discard shadow and restart at counter=0 in the first cycle after release; sample_ready=1 during and after reset.

Configuration
REQ-025 SHALL, with macro PWM_UNDERRUN_CNT_EN defined, increment underrun_cnt by 1 per underrun wrap, saturating at 255.
REQ-026 SHALL, without PWM_UNDERRUN_CNT_EN, tie underrun_cnt to 0 and omit its counter; all other behaviour identical.

Verification (SAMPLE_W=16, PWM_W=8, PWM_UNDERRUN_CNT_EN defined)
REQ-027 SHALL check: after reset, no samples -> both outputs high exactly 128 of every 256 cycles; underrun_cnt increments per period.
REQ-028 SHALL check: offer L=0x7FFF, R=0x8000 once -> from next period on, left high 255/256 cycles, right constantly low.
REQ-029 SHALL check: two back-to-back valid pairs -> first accepted immediately, second stalled (sample_ready=0) until cycle after wrap, then accepted.
REQ-030 SHALL check: accept coincident with wrap cycle, shadow empty -> old duty held one more full period, new duty in period after; underrun_cnt +1.
REQ-031 SHALL check: no samples for 300 periods -> underrun_cnt saturates at 255.
REQ-032 SHALL check: rst pulsed mid-period with shadow full -> outputs 0 during rst, then 128/256 duty, shadow discarded, underrun_cnt=0.

Source files
------------

// File: rtl/pwm_stereo_modulator.sv
// Stereo PCM-to-PWM modulator with a one-pair shadow buffer; duties swap only at period wrap.
// Define PWM_UNDERRUN_CNT_EN to build the saturating underrun counter; otherwise underrun_cnt is tied to 0.
module pwm_stereo_modulator #(
    parameter int SAMPLE_W = 16,
    parameter int PWM_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample_left,
    input  logic [SAMPLE_W-1:0] sample_right,
    output logic                sample_ready,
    output logic                left_channel,
    output logic                right_channel,
    output logic [7:0]          underrun_cnt
);

    localparam logic [PWM_W-1:0] MIDSCALE = PWM_W'(1) << (PWM_W - 1);
    localparam logic [PWM_W-1:0] TOP      = '1;

    logic [PWM_W-1:0] cnt_q, cnt_d;
    logic [PWM_W-1:0] shl_q, shr_q;
    logic [PWM_W-1:0] actl_q, actr_q;
    logic [PWM_W-1:0] duty_l, duty_r;
    logic             full_q;
    logic             left_q, right_q;
    logic             wrap, accept;
    logic             unused_bits;

    // Offset binary: flipping the sign bit maps -full..+full onto 0..2^PWM_W-1.
    assign duty_l = sample_left[SAMPLE_W-1 -: PWM_W] ^ MIDSCALE;
    assign duty_r = sample_right[SAMPLE_W-1 -: PWM_W] ^ MIDSCALE;
    assign unused_bits = ^{sample_left, sample_right};

    assign cnt_d        = cnt_q + PWM_W'(1);
    assign wrap         = (cnt_q == TOP);
    assign sample_ready = !full_q;
    assign accept       = sample_valid && !full_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            shl_q   <= '0;
            shr_q   <= '0;
            full_q  <= 1'b0;
            actl_q  <= MIDSCALE;
            actr_q  <= MIDSCALE;
            left_q  <= 1'b0;
            right_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            left_q  <= (cnt_q < actl_q);
            right_q <= (cnt_q < actr_q);
            // accept implies an empty shadow, so a wrap with a full shadow never races a new write.
            if (wrap && full_q) begin
                actl_q <= shl_q;
                actr_q <= shr_q;
                full_q <= 1'b0;
            end else if (accept) begin
                shl_q  <= duty_l;
                shr_q  <= duty_r;
                full_q <= 1'b1;
            end
        end
    end

    assign left_channel  = left_q;
    assign right_channel = right_q;

`ifdef PWM_UNDERRUN_CNT_EN
    logic [7:0] ucnt_q, ucnt_d;

    assign ucnt_d = (ucnt_q == 8'hFF) ? ucnt_q : ucnt_q + 8'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ucnt_q <= '0;
        end else if (wrap && !full_q) begin
            ucnt_q <= ucnt_d;
        end
    end

    assign underrun_cnt = ucnt_q;
`else
    assign underrun_cnt = '0;
`endif

endmodule
